// File: rtl/axi4s_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS byte-wide AXI4-Stream sources.
// A grant is held from the first beat until tlast is accepted; the granted index drives initiator_tid.
module axi4s_packet_arbiter #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_PORTS-1:0]   port_enable,
  input  logic [NUM_PORTS-1:0]   target_tvalid,
  output logic [NUM_PORTS-1:0]   target_tready,
  input  logic [NUM_PORTS-1:0]   target_tlast,
  input  logic [8*NUM_PORTS-1:0] target_tdata,
  output logic                   initiator_tvalid,
  input  logic                   initiator_tready,
  output logic                   initiator_tlast,
  output logic [7:0]             initiator_tdata,
  output logic [2:0]             initiator_tid,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  localparam int unsigned IDW   = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned DISTW = 4;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;

  logic [NUM_PORTS-1:0] cand_c;
  logic                 pick_vld_c;
  logic [IDW-1:0]       pick_c;
  logic [DISTW-1:0]     best_c;
  logic [DISTW-1:0]     dist_c;

  logic                 sel_valid_c;
  logic                 sel_last_c;
  logic [DW-1:0]        sel_data_c;

  // Mux of the port currently pointed to by grant_q
  always_comb begin
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    sel_data_c  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_valid_c = target_tvalid[i];
        sel_last_c  = target_tlast[i];
        sel_data_c  = target_tdata[DW*i +: DW];
      end
    end
  end

  // Round-robin pick: smallest rotated distance from grant_q, the last grantee being farthest
  always_comb begin
    cand_c     = target_tvalid & port_enable;
    pick_vld_c = 1'b0;
    pick_c     = grant_q;
    best_c     = DISTW'(NUM_PORTS + 1);
    dist_c     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      dist_c = DISTW'(i) + ((DISTW'(i) > DISTW'(grant_q)) ? DISTW'(0) : DISTW'(NUM_PORTS))
               - DISTW'(grant_q);
      if (cand_c[i] && (dist_c < best_c)) begin
        best_c     = dist_c;
        pick_c     = IDW'(i);
        pick_vld_c = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= IDW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          state_d = ST_LOCKED;
          grant_d = pick_c;
        end
      end
      ST_LOCKED: begin
        if (sel_valid_c && initiator_tready && sel_last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: zero-latency pass-through while locked, quiet otherwise
  always_comb begin
    initiator_tvalid = 1'b0;
    initiator_tlast  = 1'b0;
    initiator_tdata  = '0;
    target_tready    = '0;
    busy             = 1'b0;
    initiator_tid    = grant_q;
    grant_id         = grant_q;
    if (state_q == ST_LOCKED) begin
      initiator_tvalid = sel_valid_c;
      initiator_tlast  = sel_last_c;
      initiator_tdata  = sel_data_c;
      target_tready    = NUM_PORTS'(initiator_tready) << grant_q;
      busy             = 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4s_packet_arbiter.sv
// Randomized scoreboard bench for axi4s_packet_arbiter with a packet-level reference model.
module tb_axi4s_packet_arbiter;

  localparam int unsigned N = 4;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [N-1:0]     port_enable;
  logic [N-1:0]     target_tvalid;
  logic [N-1:0]     target_tready;
  logic [N-1:0]     target_tlast;
  logic [8*N-1:0]   target_tdata;
  logic             initiator_tvalid;
  logic             initiator_tready;
  logic             initiator_tlast;
  logic [7:0]       initiator_tdata;
  logic [2:0]       initiator_tid;
  logic             busy;
  logic [2:0]       grant_id;

  always #5 aclk = ~aclk;

  axi4s_packet_arbiter #(.NUM_PORTS(N)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .port_enable      (port_enable),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tlast     (target_tlast),
    .target_tdata     (target_tdata),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tlast  (initiator_tlast),
    .initiator_tdata  (initiator_tdata),
    .initiator_tid    (initiator_tid),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  typedef struct packed {
    logic         tvalid;
    logic         tlast;
    logic [7:0]   tdata;
    logic [2:0]   tid;
    logic         busy;
    logic [2:0]   gid;
    logic [N-1:0] trdy;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  // Per-port source queues: {tlast, tdata}
  logic [8:0] src_q [N][$];

  // Reference model: owner = port holding the grant (-1 when free), last = last grantee
  int owner;
  int last;

  int  bubble_pct;
  int  rdy_pct;
  bit  random_fill;
  bit  en_rand;

  task automatic add_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) src_q[p].push_back({(b == len - 1), 8'($urandom)});
  endtask

  task automatic run_cycle(input bit rst_now);
    obs_t e;
    int   acc;
    aresetn = !rst_now;
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() == 0) target_tvalid[p] = 1'b0;
      else if (!target_tvalid[p] && ($urandom_range(99) >= bubble_pct)) target_tvalid[p] = 1'b1;
      if (src_q[p].size() > 0) begin
        target_tlast[p]       = src_q[p][0][8];
        target_tdata[8*p +: 8] = src_q[p][0][7:0];
      end else begin
        target_tlast[p]       = 1'($urandom);
        target_tdata[8*p +: 8] = 8'($urandom);
      end
    end
    initiator_tready = ($urandom_range(99) < rdy_pct);
    if (en_rand && ($urandom_range(9) == 0)) port_enable = N'($urandom);

    if (rst_now) begin
      owner = -1;
      last  = N - 1;
    end
    e = '0;
    e.tid = 3'(last);
    e.gid = 3'(last);
    if (owner >= 0) begin
      e.tvalid = target_tvalid[owner];
      e.tlast  = target_tlast[owner];
      e.tdata  = target_tdata[8*owner +: 8];
      e.busy   = 1'b1;
      e.trdy   = initiator_tready ? (N'(1) << owner) : '0;
    end
    exp_q.push_back(e);

    acc = -1;
    if (!rst_now) begin
      if (owner >= 0) begin
        if (target_tvalid[owner] && initiator_tready) begin
          acc = owner;
          if (target_tlast[owner]) owner = -1;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (last + k) % N;
          if (owner < 0 && target_tvalid[p] && port_enable[p]) begin
            owner = p;
            last  = p;
          end
        end
      end
    end

    @(posedge aclk);
    #1;
    cyc++;
    if (acc >= 0) begin
      void'(src_q[acc].pop_front());
      target_tvalid[acc] = 1'b0;
    end
    if (random_fill)
      for (int p = 0; p < N; p++)
        if (src_q[p].size() == 0 && $urandom_range(3) == 0) add_pkt(p, $urandom_range(1, 4));
  endtask

  // Direct check of spec reset values while reset is held
  task automatic check_reset_outputs();
    vectors++;
    if (initiator_tvalid !== 1'b0 || initiator_tlast !== 1'b0 || initiator_tdata !== 8'h00 ||
        initiator_tid !== 3'(N - 1) || grant_id !== 3'(N - 1) || busy !== 1'b0 ||
        target_tready !== '0) begin
      miscompares++;
      $display("FAIL cycle %0d reset values: tv=%b tl=%b d=%h tid=%0d gid=%0d busy=%b trdy=%b",
               cyc, initiator_tvalid, initiator_tlast, initiator_tdata, initiator_tid,
               grant_id, busy, target_tready);
    end
  endtask

  // Run until every source queue has drained, flagging an expired wait
  task automatic drain(input int unsigned max_cycles);
    int unsigned n;
    bit          pending;
    random_fill = 1'b0;
    en_rand     = 1'b0;
    port_enable = '1;
    n           = 0;
    pending     = 1'b1;
    while (pending && n < max_cycles) begin
      pending = 1'b0;
      for (int p = 0; p < N; p++) if (src_q[p].size() != 0) pending = 1'b1;
      if (pending) begin
        run_cycle(1'b0);
        n++;
      end
    end
    pending = 1'b0;
    for (int p = 0; p < N; p++) if (src_q[p].size() != 0) pending = 1'b1;
    vectors++;
    if (pending) begin
      miscompares++;
      $display("FAIL cycle %0d: wait expired after %0d cycles with beats still queued", cyc, n);
    end
  endtask

  // Monitor: one expected observation per cycle, sampled mid-cycle
  always @(negedge aclk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = '{tvalid: initiator_tvalid, tlast: initiator_tlast, tdata: initiator_tdata,
            tid: initiator_tid, busy: busy, gid: grant_id, trdy: target_tready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got tv=%b tl=%b d=%h tid=%0d busy=%b gid=%0d trdy=%b, want tv=%b tl=%b d=%h tid=%0d busy=%b gid=%0d trdy=%b",
                 cyc, a.tvalid, a.tlast, a.tdata, a.tid, a.busy, a.gid, a.trdy,
                 e.tvalid, e.tlast, e.tdata, e.tid, e.busy, e.gid, e.trdy);
      end
    end
  end

  initial begin
    aresetn          = 1'b0;
    port_enable      = '1;
    target_tvalid    = '0;
    target_tlast     = '0;
    target_tdata     = '0;
    initiator_tready = 1'b0;
    owner            = -1;
    last             = N - 1;
    bubble_pct       = 0;
    rdy_pct          = 100;
    random_fill      = 1'b0;
    en_rand          = 1'b0;
    @(posedge aclk);
    #1;

    // Reset values
    run_cycle(1'b1);
    run_cycle(1'b1);
    check_reset_outputs();

    // Single requester: port 2 sends A1,A2,A3
    src_q[2].push_back({1'b0, 8'hA1});
    src_q[2].push_back({1'b0, 8'hA2});
    src_q[2].push_back({1'b1, 8'hA3});
    repeat (6) run_cycle(1'b0);

    // Round-robin: all ports with back-to-back 2-beat packets
    for (int p = 0; p < N; p++) repeat (3) add_pkt(p, 2);
    repeat (40) run_cycle(1'b0);
    drain(200);

    // Backpressure on a 4-beat packet from port 1
    rdy_pct = 50;
    add_pkt(1, 4);
    repeat (20) run_cycle(1'b0);

    // Enable mask 1010, then drop port 1 while it may hold the grant
    rdy_pct     = 100;
    port_enable = 4'b1010;
    for (int p = 0; p < N; p++) repeat (2) add_pkt(p, 3);
    repeat (10) run_cycle(1'b0);
    port_enable = 4'b1000;
    repeat (20) run_cycle(1'b0);
    port_enable = '1;
    repeat (20) run_cycle(1'b0);

    // Source bubbles on ports 0 and 3
    bubble_pct = 60;
    add_pkt(0, 4);
    add_pkt(3, 2);
    repeat (30) run_cycle(1'b0);

    // Mid-packet reset on a port 2 packet, then a port 0 request
    bubble_pct = 0;
    add_pkt(2, 4);
    repeat (3) run_cycle(1'b0);
    run_cycle(1'b1);
    check_reset_outputs();
    src_q[2].delete();
    target_tvalid = '0;
    add_pkt(0, 2);
    repeat (6) run_cycle(1'b0);

    // Fully random traffic with occasional resets and enable changes
    bubble_pct  = 30;
    rdy_pct     = 70;
    random_fill = 1'b1;
    en_rand     = 1'b1;
    for (int c = 0; c < 3000; c++) run_cycle($urandom_range(499) == 0);
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4s_packet_arbiter.md
# axi4s_packet_arbiter

Packet-level round-robin arbiter that shares one 8-bit AXI4-Stream path between up to eight requesters. It sits upstream of the destination-insert stage. A grant is held from the first beat to the `tlast` beat of a packet, and the granted port index is driven on `initiator_tid`. The downstream stage prepends that index as the packet header byte.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of target ports; legal range 2..8.

Ports:
- `aclk`, input, 1: clock.
- `aresetn`, input, 1: reset; asynchronous, active-low.
- `port_enable`, input, NUM_PORTS: per-port arbitration enable; bit i = 0 excludes port i from new grants.
- `target_tvalid`, input, NUM_PORTS: per-port valid.
- `target_tready`, output, NUM_PORTS: per-port ready.
- `target_tlast`, input, NUM_PORTS: per-port last.
- `target_tdata`, input, 8*NUM_PORTS: per-port data; port i occupies bits [8i+7:8i].
- `initiator_tvalid`, output, 1: merged stream valid.
- `initiator_tready`, input, 1: merged stream ready.
- `initiator_tlast`, output, 1: merged stream last.
- `initiator_tdata`, output, 8: merged stream data.
- `initiator_tid`, output, 3: index of the granted port, zero-extended.
- `busy`, output, 1: high while a grant is held (LOCKED).
- `grant_id`, output, 3: registered index of the current or last grant.

## Operation
- States: IDLE and LOCKED. Reset state is IDLE.
- Registers: `grant_id` (reset NUM_PORTS-1, so port 0 has first priority).
- IDLE:
  - Candidates are ports with `target_tvalid[i] && port_enable[i]`.
  - If any candidate exists, pick the first one scanning upward from `grant_id+1`, wrapping at NUM_PORTS-1 → 0.
  - Register the pick into `grant_id` and move to LOCKED on the next edge.
  - No candidate: stay in IDLE; `grant_id` is unchanged.
- LOCKED:
  - Output is a combinational mux of port `grant_id`: `initiator_tvalid/tlast/tdata` follow that port.
  - `target_tready[grant_id] = initiator_tready`.
  - `initiator_tid = grant_id`.
  - On a handshake (`initiator_tvalid && initiator_tready`) with `initiator_tlast = 1`, move to IDLE.
- `target_tready` of every non-granted port is 0 in every state. All `target_tready` are 0 in IDLE.
- In IDLE: `initiator_tvalid = 0`, `initiator_tlast = 0`, `initiator_tdata = 0`, `initiator_tid = grant_id`.
- `port_enable` is sampled only in IDLE. Deasserting it for the granted port during LOCKED does not truncate or abort the packet.
- Granted port drops `tvalid` mid-packet: remain LOCKED; `initiator_tvalid` follows it low; no rearbitration until `tlast` is accepted.
- Single-beat packet (first beat has `tlast`): one LOCKED cycle if `initiator_tready = 1`, then IDLE.
- Output handshake signals obey AXI4-Stream rules: once the granted port asserts `tvalid`, the block forwards it unchanged until accepted. The block never drops or reorders beats within a packet.
- Reset mid-packet: immediate return to IDLE. `grant_id` resets to NUM_PORTS-1 and all readies go to 0. The partial packet is the upstream's responsibility.

## Timing
- Arbitration latency: 1 cycle. A candidate's `tvalid` seen in IDLE at edge N → LOCKED from edge N. The first beat can be accepted in cycle N+1.
- Datapath latency in LOCKED: 0 cycles (combinational). Throughput is 1 beat/cycle within a packet.
- Packet gap: at least 1 idle cycle between consecutive packets, from the IDLE cycle after `tlast`.
- Output reset values: `initiator_tvalid = 0`, `initiator_tlast = 0`, `initiator_tdata = 0`, `initiator_tid = NUM_PORTS-1`, `target_tready = 0`, `busy = 0`, `grant_id = NUM_PORTS-1`.
- Fairness: with all ports continuously requesting, grants rotate 0,1,…,NUM_PORTS-1,0. Each port waits at most NUM_PORTS-1 packets.

## Test plan
- Single requester: NUM_PORTS=4, port 2 sends a 3-byte packet 0xA1,0xA2,0xA3 with `initiator_tready = 1` → IDLE cycle, then three output beats with `tid = 2` and `tlast` on 0xA3; `busy` is high for exactly 3 cycles.
- Round-robin: all 4 ports continuously send 2-beat packets → output tid sequence 0,1,2,3,0; each packet is contiguous; a 1-cycle gap separates packets.
- Backpressure: port 1 sends a 4-beat packet; `initiator_tready` toggles 1,0,0,1,… → output data is stable while stalled; `target_tready[1]` mirrors `initiator_tready`; no beat is lost or duplicated; other ports see `tready = 0` throughout.
- Enable mask: `port_enable = 4'b1010` with all ports valid → only ports 1 and 3 are granted, alternating. Clearing bit 1 mid-packet completes the current packet from port 1, then only port 3 is granted.
- Granted-source bubble: port 0 drops `tvalid` for 3 cycles mid-packet while port 3 is valid → block stays LOCKED on port 0 with `initiator_tvalid = 0`; port 3 is granted only after port 0's `tlast`.
- Reset mid-packet: assert `aresetn = 0` during beat 2 of a port 2 packet → all outputs at reset values in the same cycle. After release, a port 0 request is granted first.
